// File: rtl/seq_hit_monitor.sv
// seq_hit_monitor: windowed hit counter with alarm and saturating total.
// Optional sticky alarm with alarm_ack port: define SEQ_MON_STICKY_EN.
module seq_hit_monitor #(
  parameter int CNT_W   = 8,
  parameter int TOT_W   = 16,
  parameter int WIN_LEN = 16,
  parameter int THRESH  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             hit,
`ifdef SEQ_MON_STICKY_EN
  input  logic             alarm_ack,
`endif
  output logic [CNT_W-1:0] win_count,
  output logic             win_done,
  output logic             alarm,
  output logic [TOT_W-1:0] total
);

  localparam int CYC_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [CYC_W-1:0] LAST = CYC_W'(WIN_LEN - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q;
  logic [CYC_W-1:0] cyc_q;
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] acc_d;
  logic [TOT_W-1:0] tot_q;
  logic [TOT_W-1:0] tot_d;
  logic [CNT_W-1:0] wc_q;
  logic             done_q;
  logic             alarm_q;
  logic             alarm_d;
  logic             at_end;
  logic             over;

  // Saturating increments and the end-of-window alarm decision.
  always_comb begin
    acc_d = acc_q;
    tot_d = tot_q;
    if (hit && (acc_q != {CNT_W{1'b1}}))
      acc_d = acc_q + 1'b1;
    if (hit && (tot_q != {TOT_W{1'b1}}))
      tot_d = tot_q + 1'b1;
    at_end = (state_q == RUN) && en && (cyc_q == LAST);
    over = (32'(acc_d) >= 32'(THRESH));
`ifdef SEQ_MON_STICKY_EN
    if (at_end && over)
      alarm_d = 1'b1;
    else if (alarm_ack)
      alarm_d = 1'b0;
    else
      alarm_d = alarm_q;
`else
    alarm_d = at_end ? over : alarm_q;
`endif
  end

  // Window FSM, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      acc_q   <= '0;
      tot_q   <= '0;
      wc_q    <= '0;
      done_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else if (clr) begin
      cyc_q   <= '0;
      acc_q   <= '0;
      tot_q   <= '0;
      wc_q    <= '0;
      done_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      alarm_q <= alarm_d;
      unique case (state_q)
        IDLE: begin
          cyc_q <= '0;
          acc_q <= '0;
          if (en)
            state_q <= RUN;
        end
        RUN: begin
          if (!en) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            acc_q   <= '0;
          end else begin
            tot_q <= tot_d;
            if (at_end) begin
              wc_q   <= acc_d;
              done_q <= 1'b1;
              acc_q  <= '0;
              cyc_q  <= '0;
            end else begin
              acc_q <= acc_d;
              cyc_q <= cyc_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign win_count = wc_q;
  assign win_done  = done_q;
  assign alarm     = alarm_q;
  assign total     = tot_q;

endmodule

// File: tb/tb_seq_hit_monitor.sv
// tb_seq_hit_monitor: table vectors, directed corners and random
// stimulus against a cycle-level behavioural model.
module tb_seq_hit_monitor;

  localparam int CNT_W = 2;
  localparam int TOT_W = 8;
  localparam int WIN   = 16;
  localparam int TH    = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int TMAX  = (1 << TOT_W) - 1;

  logic clk = 1'b0;
  logic rst, en, clr, hit;
  logic [CNT_W-1:0] win_count;
  logic win_done, alarm;
  logic [TOT_W-1:0] total;

  int n_tests = 0;
  int n_fail = 0;

  // model state (unsaturated integers, clipped on publish)
  bit m_run;
  int m_pos, m_cnt, m_tot, m_wc;
  bit m_alarm, m_done;

  always #5 clk = ~clk;

  seq_hit_monitor #(
    .CNT_W(CNT_W), .TOT_W(TOT_W),
    .WIN_LEN(WIN), .THRESH(TH)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .clr(clr), .hit(hit),
`ifdef SEQ_MON_STICKY_EN
    .alarm_ack(1'b0),
`endif
    .win_count(win_count), .win_done(win_done),
    .alarm(alarm), .total(total)
  );

  function automatic int min2(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model(bit r, bit e, bit c, bit h);
    if (r) begin
      m_run = 0; m_pos = 0; m_cnt = 0; m_tot = 0;
      m_wc = 0; m_alarm = 0; m_done = 0;
    end else if (c) begin
      m_pos = 0; m_cnt = 0; m_tot = 0;
      m_wc = 0; m_alarm = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (!m_run) begin
        if (e) m_run = 1;
      end else if (!e) begin
        m_run = 0; m_pos = 0; m_cnt = 0;
      end else begin
        m_tot += h;
        m_cnt += h;
        if (m_pos == WIN - 1) begin
          m_wc = min2(m_cnt, CMAX);
          m_alarm = (m_wc >= TH);
          m_done = 1;
          m_cnt = 0;
          m_pos = 0;
        end else begin
          m_pos++;
        end
      end
    end
  endtask

  task automatic chk(string nm, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // one clock: drive, advance model, compare all outputs
  task automatic step(string nm, bit r, bit e, bit c, bit h);
    rst = r; en = e; clr = c; hit = h;
    @(posedge clk);
    model(r, e, c, h);
    #1;
    chk({nm, ".done"}, int'(win_done), int'(m_done));
    chk({nm, ".cnt"}, int'(win_count), m_wc);
    chk({nm, ".alarm"}, int'(alarm), int'(m_alarm));
    chk({nm, ".total"}, int'(total), min2(m_tot, TMAX));
  endtask

  typedef struct {
    logic [WIN-1:0] mask;
    int             cnt;
    bit             alm;
    int             tot;
  } vec_t;

  vec_t vt[5];

  initial begin
    vt[0] = '{16'h0224, 3, 1'b1, 3};
    vt[1] = '{16'h8000, 1, 1'b0, 4};
    vt[2] = '{16'hFFFF, 3, 1'b1, 20};
    vt[3] = '{16'h0000, 0, 1'b0, 20};
    vt[4] = '{16'h0003, 2, 1'b0, 22};

    rst = 1; en = 0; clr = 0; hit = 0;
    @(negedge clk);

    // reset, then idle with hit toggling
    step("rst", 1, 0, 0, 0);
    step("rst", 1, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step("idle", 0, 0, 0, i[0]);
      chk("idle.zero", int'(win_done | alarm) + int'(total), 0);
    end

    // IDLE -> RUN, then back-to-back windows from the table
    step("start", 0, 1, 0, 1);
    for (int w = 0; w < 5; w++) begin
      for (int c = 0; c < WIN; c++)
        step("win", 0, 1, 0, vt[w].mask[c]);
      chk("tbl.done", int'(win_done), 1);
      chk("tbl.cnt", int'(win_count), vt[w].cnt);
      chk("tbl.alarm", int'(alarm), int'(vt[w].alm));
      chk("tbl.total", int'(total), vt[w].tot);
    end

    // mid-window disable: partial window dropped, outputs hold
    for (int c = 0; c < 6; c++)
      step("part", 0, 1, 0, (c == 1 || c == 3));
    step("dis", 0, 0, 0, 1);
    chk("dis.total", int'(total), 24);
    chk("dis.cnt", int'(win_count), 2);
    step("restart", 0, 1, 0, 1);
    for (int c = 0; c < WIN; c++) begin
      step("rewin", 0, 1, 0, (c == 0));
      chk("rewin.done", int'(win_done), (c == WIN - 1) ? 1 : 0);
    end
    chk("rewin.cnt", int'(win_count), 1);

    // window with alarm, then clr on a window's last cycle
    for (int c = 0; c < WIN; c++)
      step("pre", 0, 1, 0, (c < 4));
    chk("pre.alarm", int'(alarm), 1);
    for (int c = 0; c < WIN - 1; c++)
      step("clrw", 0, 1, 0, 1);
    step("clr", 0, 1, 1, 1);
    chk("clr.done", int'(win_done), 0);
    chk("clr.total", int'(total), 0);
    chk("clr.cnt", int'(win_count), 0);
    chk("clr.alarm", int'(alarm), 0);
    // clr kept RUN: next WIN cycles form a full window
    for (int c = 0; c < WIN; c++)
      step("postclr", 0, 1, 0, 0);
    chk("postclr.done", int'(win_done), 1);

    // total saturation
    for (int c = 0; c < 300; c++)
      step("sat", 0, 1, 0, 1);
    chk("sat.total", int'(total), TMAX);
    chk("sat.cnt", int'(win_count), CMAX);

    // random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      step("rnd", ($urandom_range(0, 199) == 0),
           ($urandom_range(0, 19) != 0),
           ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) < 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
